// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge: single-beat core-to-IO bridge.
// Decodes a device from the upper address bits, strobes it, and waits for ack or timeout.
module sys_bus_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int LOCAL_AW = 12,
  parameter int IO_NUM   = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [LOCAL_AW-1:0]      io_addr,
  output logic [DATA_W-1:0]        io_wdata,
  output logic [IO_NUM-1:0]        io_rd_en,
  output logic [IO_NUM-1:0]        io_wr_en,
  input  logic [IO_NUM*DATA_W-1:0] io_rdata,
  input  logic [IO_NUM-1:0]        io_ack
);

  localparam int IW = ADDR_W - LOCAL_AW;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ADDR   = 4'b0010,
    S_ACCESS = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic                r_write;
  logic [CW-1:0]       r_cnt;
  logic                r_req_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [LOCAL_AW-1:0] r_io_addr;
  logic [DATA_W-1:0]   r_io_wdata;
  logic [IO_NUM-1:0]   r_io_rd_en;
  logic [IO_NUM-1:0]   r_io_wr_en;

  logic [IO_NUM-1:0]   w_dec;
  logic [IO_NUM-1:0]   w_stb;
  logic                w_ack;
  logic [DATA_W-1:0]   w_rdata;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_tmo;

  // The live strobe mask doubles as the device select during ACCESS.
  always_comb begin
    w_dec   = '0;
    w_rdata = '0;
    w_stb   = r_io_rd_en | r_io_wr_en;
    w_ack   = |(io_ack & w_stb);
    for (int k = 0; k < IO_NUM; k++) begin
      w_dec[k] = (32'(r_idx) == k);
      if (w_stb[k])
        w_rdata = io_rdata[k*DATA_W +: DATA_W];
    end
    w_cnt_nxt = r_cnt + CW'(1);
    w_tmo     = (w_cnt_nxt == CW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_io_addr   <= '0;
      r_io_wdata  <= '0;
      r_io_rd_en  <= '0;
      r_io_wr_en  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_idx       <= req_addr[ADDR_W-1:LOCAL_AW];
            r_write     <= req_write;
            r_io_addr   <= req_addr[LOCAL_AW-1:0];
            r_io_wdata  <= req_wdata;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_cnt <= '0;
          if (|w_dec) begin
            r_io_rd_en <= r_write ? '0 : w_dec;
            r_io_wr_en <= r_write ? w_dec : '0;
            r_state    <= S_ACCESS;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= S_DONE;
          end
        end
        S_ACCESS: begin
          if (w_ack) begin
            r_io_rd_en  <= '0;
            r_io_wr_en  <= '0;
            r_rsp_rdata <= r_write ? '0 : w_rdata;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_tmo) begin
            r_io_rd_en  <= '0;
            r_io_wr_en  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_cnt       <= '0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign io_addr   = r_io_addr;
  assign io_wdata  = r_io_wdata;
  assign io_rd_en  = r_io_rd_en;
  assign io_wr_en  = r_io_wr_en;

endmodule

// File: tb/tb_sys_bus_bridge.sv
// tb_sys_bus_bridge: directed and random transactions against a
// transaction-level model of strobe windows, latency and response.
module tb_sys_bus_bridge;

  localparam int TMO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_write;
  logic [15:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic         busy;
  logic [11:0]  io_addr;
  logic [31:0]  io_wdata;
  logic [3:0]   io_rd_en;
  logic [3:0]   io_wr_en;
  logic [127:0] io_rdata;
  logic [3:0]   io_ack;
  logic [31:0]  dev_data [4];

  int n_chk = 0;
  int n_fail = 0;

  sys_bus_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rd_en  (io_rd_en),
    .io_wr_en  (io_wr_en),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack)
  );

  always #5 clk = ~clk;

  always_comb
    io_rdata = {dev_data[3], dev_data[2], dev_data[1], dev_data[0]};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // dly = strobe cycles before the ack cycle; dly >= TMO means no ack.
  task automatic txn(input logic [15:0] a, input logic w,
                     input logic [31:0] wd, input int dly,
                     input bit spur, input bit hold);
    int       idx;
    bit       dec_ok;
    bit       exp_err;
    int       nstb;
    int       rsp_c;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    bit       act;
    bit       ready_seen;
    idx     = int'(a[15:12]);
    dec_ok  = idx < 4;
    sel     = dec_ok ? 4'(1 << idx) : 4'b0;
    nstb    = 0;
    exp_err = 1'b1;
    if (dec_ok) begin
      nstb    = (dly < TMO) ? dly + 1 : TMO;
      exp_err = (dly >= TMO);
    end
    rsp_c  = 2 + nstb;
    exp_rd = (exp_err || w) ? 32'h0 : dev_data[idx];

    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    ready_seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (req_ready) begin
        ready_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ready_seen) begin
      chk("accept_wait", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= rsp_c; c++) begin
      @(negedge clk);
      act = dec_ok && c >= 2 && c < 2 + nstb;
      chk("rd_en", io_rd_en, (act && !w) ? sel : 4'b0);
      chk("wr_en", io_wr_en, (act && w) ? sel : 4'b0);
      chk("rsp_valid", rsp_valid, c == rsp_c);
      chk("req_ready", req_ready, 0);
      chk("busy", busy, 1);
      if (c == 2 || c == rsp_c) begin
        chk("io_addr", io_addr, a[11:0]);
        chk("io_wdata", io_wdata, wd);
      end
      if (c == rsp_c) begin
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
      end
      io_ack = 4'b0;
      if (spur)
        io_ack = act ? (4'($urandom) & ~sel) : 4'($urandom);
      if (dec_ok && c == 2 + dly)
        io_ack = io_ack | sel;
      if (c == rsp_c)
        io_ack = 4'b0;
      if (hold) begin
        req_addr  = 16'($urandom);
        req_wdata = $urandom;
        req_write = 1'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [15:0] ra;
    int          r;
    int          dly;
    bit          seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    io_ack    = '0;
    for (int k = 0; k < 4; k++) dev_data[k] = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_io_addr", io_addr, 0);
    chk("rst_io_wdata", io_wdata, 0);
    chk("rst_rd_en", io_rd_en, 0);
    chk("rst_wr_en", io_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);

    dev_data[2] = 32'hDEADBEEF;
    txn(16'h2010, 1'b0, 32'h0, 2, 1'b0, 1'b0);
    txn(16'h0004, 1'b1, 32'h12345678, 0, 1'b0, 1'b0);
    txn(16'h5000, 1'b0, 32'h0, 0, 1'b1, 1'b0);
    txn(16'h1abc, 1'b0, 32'h0, 99, 1'b0, 1'b0);
    txn(16'h1abc, 1'b0, 32'h0, TMO - 1, 1'b0, 1'b0);
    txn(16'hF000, 1'b1, 32'hCAFEF00D, 0, 1'b0, 1'b0);
    txn(16'h3100, 1'b0, 32'h0, 4, 1'b1, 1'b1);
    txn(16'h3104, 1'b1, 32'hA5A5A5A5, 1, 1'b1, 1'b1);
    txn(16'h0200, 1'b0, 32'h0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 4; k++) dev_data[k] = $urandom;
      ra = 16'($urandom);
      ra[15:12] = 4'($urandom_range(0, 6));
      r = $urandom_range(0, 9);
      dly = (r < 8) ? r : ((r == 8) ? TMO - 1 : 40);
      txn(ra, 1'($urandom), $urandom, dly, 1'($urandom), 1'($urandom));
    end
    req_valid = 1'b0;
    @(negedge clk);

    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0008;
    req_wdata = 32'h0BADF00D;
    seen = 1'b0;
    for (int t = 0; t < 10 && !req_ready; t++) @(negedge clk);
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("pre_rst_wr_en", io_wr_en, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_en", io_wr_en, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid || io_wr_en != 0) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 0);

    dev_data[1] = 32'h13579BDF;
    txn(16'h1FFC, 1'b0, 32'h0, 3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_bus_bridge.md
Name: sys_bus_bridge

Overview:
- Parametrised next-generation system bus controller between the core-side controller and IO_NUM memory-mapped IO devices.
- Decodes the device index from the upper address bits and drives a one-hot read/write strobe to the selected device.
- Waits for a per-device acknowledge (variable wait states), with timeout and decode-error reporting.
- Returns read data and status through a single-beat valid/ready request/response handshake.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 16, full bus address width.
- LOCAL_AW, 12, device-local address width; device index = req_addr[ADDR_W-1:LOCAL_AW].
- IO_NUM, 4, number of attached IO devices (1..2^(ADDR_W-LOCAL_AW)).
- TIMEOUT, 15, maximum ACCESS cycles without acknowledge (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  controller request present.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  full address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  bridge can accept a request (IDLE).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  decode error or timeout; valid with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- io_addr  out  LOCAL_AW  device-local address.
- io_wdata  out  DATA_W  write data to devices.
- io_rd_en  out  IO_NUM  one-hot read strobe.
- io_wr_en  out  IO_NUM  one-hot write strobe.
- io_rdata  in  IO_NUM*DATA_W  flattened read data; device k occupies [k*DATA_W +: DATA_W].
- io_ack  in  IO_NUM  device k completes its access.

Behaviour:
- Clock and reset: clk is the clock; rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - req_ready = 1.
  - busy, rsp_valid, rsp_err = 0.
  - rsp_rdata, io_addr, io_wdata, io_rd_en, io_wr_en = 0.
  - State = IDLE; timeout counter = 0.
- FSM, one-hot, states IDLE, ADDR, ACCESS, DONE:
  - IDLE: req_ready = 1. When req_valid = 1 at an edge, latch addr/write/wdata, set req_ready = 0 and busy = 1, go to ADDR.
  - ADDR (1 cycle):
    - Drive io_addr = latched addr[LOCAL_AW-1:0] and io_wdata = latched wdata.
    - Compute idx = upper address bits.
    - If idx >= IO_NUM, go to DONE with err = 1 and no strobe ever asserted.
    - Otherwise go to ACCESS, asserting io_rd_en[idx] (read) or io_wr_en[idx] (write) on entry.
  - ACCESS:
    - The strobe is held constant and the counter increments every cycle.
    - When io_ack[idx] is sampled high: deassert the strobe, capture io_rdata slice idx into rsp_rdata (reads only), go to DONE with err = 0.
    - Otherwise, when the counter reaches TIMEOUT: deassert the strobe, rsp_rdata = 0, go to DONE with err = 1.
    - If ack and timeout occur in the same cycle, ack wins.
  - DONE: rsp_valid = 1 and rsp_err valid for exactly one cycle, then go to IDLE. The counter clears. req_ready returns to 1 on the next cycle.
- Latency, with acceptance at edge 0:
  - ADDR during cycle 1.
  - Strobe high from cycle 2.
  - Ack sampled at edge n gives rsp_valid in the cycle after edge n.
  - Zero-wait (ack in the first ACCESS cycle): rsp_valid in cycle 3.
- io_ack bits of non-selected devices, and any ack outside ACCESS, are ignored.
- req_valid while req_ready = 0 is ignored; it is not queued.
- io_addr and io_wdata hold their values after a transaction until the next ADDR.
- Never more than one strobe bit is high, and never io_rd_en and io_wr_en together.
- Reset asserted mid-transaction: at the next edge all strobes drop, no response is issued, state = IDLE.

Test Plan:
- Read: addr 0x2010 (idx 2), io_rdata slice2 = 0xDEADBEEF, ack 3 cycles after strobe -> io_rd_en = 4'b0100 for 3 cycles, io_addr = 0x010, rsp_valid with rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Write: addr 0x0004, wdata 0x12345678, immediate ack -> io_wr_en = 4'b0001 for 1 cycle, io_wdata = 0x12345678, rsp_valid in cycle 3, rsp_rdata = 0, rsp_err = 0.
- Decode error: addr 0x5000 (idx 5 >= 4) -> no strobe, rsp_valid with rsp_err = 1 at cycle 2.
- Timeout: read idx 1, no ack -> io_rd_en[1] high for 15 cycles, then rsp_err = 1 and rsp_rdata = 0.
- Spurious ack plus back-to-back: during a read of idx 3, pulse io_ack[0] -> ignored, strobe stays high; io_ack[3] completes the read. A request held valid is re-accepted on the cycle req_ready rises.
- Reset mid-ACCESS: rst high during a write strobe -> next edge io_wr_en = 0, rsp_valid stays 0, req_ready = 1.
